// File: rtl/spi_cfg_master_if.sv
// Configuration link between an SPI master endpoint and its attached register.
// The master side owns wdata; the register side supplies rdata, its address and reset value.
interface spi_cfg_interface #(
  parameter int ASIZE = 15,
  parameter int DSIZE = 16
);
  logic [DSIZE-1:0] wdata;
  logic [DSIZE-1:0] rdata;
  logic [DSIZE-1:0] default_data;
  logic [ASIZE-1:0] cfg_addr;

  modport master (output wdata, input rdata, input cfg_addr, input default_data);
  modport slave  (input wdata, output rdata, output cfg_addr, output default_data);
endinterface

// File: rtl/spi_cfg_master.sv
// SPI mode-0 target decoding {rw, addr, data} frames for one configuration register.
// Latency: SPI edges act 3 clocks after they occur; no backpressure, host paces the frame.
module spi_cfg_master #(
  parameter int ASIZE = 15,
  parameter int DSIZE = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  spi_cfg_interface.master        cfg_inf,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic                    wr_strobe
);

  localparam int FLEN = 1 + ASIZE + DSIZE;
  localparam int SW   = (ASIZE + 1 > DSIZE) ? ASIZE + 1 : DSIZE;
  localparam int CW   = $clog2(FLEN + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CW-1:0] CMD_LAST  = CW'(ASIZE);
  localparam logic [CW-1:0] DATA_LAST = CW'(FLEN - 1);

  logic sck_s1, sck_s2, sck_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [SW-2:0]    rx_sr;
  logic [DSIZE-2:0] tx_sr;
  logic             rw;
  logic             match;
  logic             init_done;

  logic          sck_rise, sck_fall, cs_rise, cs_fall, cs_active;
  logic [SW-1:0] rx_next;

  // cs_n synchroniser resets high so release of reset never looks like a select
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise  =  sck_s2 & ~sck_s3;
  assign sck_fall  = ~sck_s2 &  sck_s3;
  assign cs_fall   = ~cs_s2  &  cs_s3;
  assign cs_rise   =  cs_s2  & ~cs_s3;
  assign cs_active = ~cs_s2;
  assign rx_next   = {rx_sr, mosi_s2};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cfg_inf.wdata <= '0;
      miso          <= 1'b0;
      miso_oe       <= 1'b0;
      wr_strobe     <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      rw            <= 1'b0;
      match         <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (!init_done) begin
        cfg_inf.wdata <= cfg_inf.default_data;
        init_done     <= 1'b1;
      end
      // Deselect beats any simultaneous sck edge, so a late final rise cannot commit
      if (cs_rise) begin
        state   <= IDLE;
        miso_oe <= 1'b0;
        miso    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state <= CMD;
              cnt   <= '0;
              rx_sr <= '0;
            end
          end
          CMD: begin
            if (sck_rise && cs_active) begin
              rx_sr <= rx_next[SW-2:0];
              cnt   <= cnt + 1'b1;
              if (cnt == CMD_LAST) begin
                rw    <= rx_next[ASIZE];
                match <= (rx_next[ASIZE-1:0] == cfg_inf.cfg_addr);
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (sck_rise && cs_active) begin
              rx_sr <= rx_next[SW-2:0];
              cnt   <= cnt + 1'b1;
              if (cnt == DATA_LAST) begin
                if (!rw && match) begin
                  cfg_inf.wdata <= rx_next[DSIZE-1:0];
                  wr_strobe     <= 1'b1;
                end
                state <= DONE;
              end
            end else if (sck_fall && cs_active && rw && match) begin
              // miso_oe doubles as the "rdata already sampled" flag for this frame
              if (!miso_oe) begin
                tx_sr   <= cfg_inf.rdata[DSIZE-2:0];
                miso    <= cfg_inf.rdata[DSIZE-1];
                miso_oe <= 1'b1;
              end else begin
                tx_sr <= {tx_sr[DSIZE-3:0], 1'b0};
                miso  <= tx_sr[DSIZE-2];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: reset load, writes, reads, mismatches, aborts, back-to-back.
module tb_spi_cfg_master;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic sck   = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  logic miso, miso_oe, wr_strobe;

  spi_cfg_interface #(.ASIZE(15), .DSIZE(16)) cfg_if ();

  spi_cfg_master #(.ASIZE(15), .DSIZE(16)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .cfg_inf   (cfg_if.master),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .wr_strobe (wr_strobe)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int miso_bad = 0;
  logic oe_seen = 1'b0;
  logic oe_before = 1'b0;
  logic [15:0] cap = '0;

  always @(negedge clock) begin
    if (wr_strobe) strobe_cnt++;
    if (miso_oe) oe_seen = 1'b1;
    if (!miso_oe && miso) miso_bad++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    strobe_cnt = 0;
    oe_seen    = 1'b0;
  endtask

  // bits[39] is sent first; the host samples miso just before raising sck on data bits
  task automatic xfer(input logic [39:0] bits, input int n, input int gap);
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      mosi = bits[39-i];
      wait_clk(5);
      if (i >= 16 && i < 32) cap = {cap[14:0], miso};
      sck = 1'b1;
      wait_clk(5);
      if (i == 15) oe_before = miso_oe;
      sck = 1'b0;
    end
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(gap);
  endtask

  initial begin
    cfg_if.default_data = 16'h1234;
    cfg_if.cfg_addr     = 15'h0010;
    cfg_if.rdata        = 16'hA55A;

    wait_clk(3);
    chk("rst_wdata", 32'(cfg_if.wdata), 32'h0);
    chk("rst_oe", 32'(miso_oe), 32'h0);
    chk("rst_strobe", 32'(wr_strobe), 32'h0);
    rst_n = 1'b1;
    chk("pre_init_wdata", 32'(cfg_if.wdata), 32'h0);
    clr_mon();
    wait_clk(1);
    chk("init_wdata", 32'(cfg_if.wdata), 32'h1234);
    wait_clk(4);
    chk("init_strobe", 32'(strobe_cnt), 32'd0);

    clr_mon();
    xfer({1'b0, 15'h0010, 16'hBEEF, 8'h00}, 32, 6);
    chk("wr_wdata", 32'(cfg_if.wdata), 32'hBEEF);
    chk("wr_strobe_cnt", 32'(strobe_cnt), 32'd1);
    chk("wr_oe", 32'(oe_seen), 32'h0);

    clr_mon();
    xfer({1'b0, 15'h0011, 16'h0BAD, 8'h00}, 32, 6);
    chk("mis_wr_wdata", 32'(cfg_if.wdata), 32'hBEEF);
    chk("mis_wr_strobe", 32'(strobe_cnt), 32'd0);
    chk("mis_wr_oe", 32'(oe_seen), 32'h0);

    clr_mon();
    xfer({1'b1, 15'h0011, 16'h0000, 8'h00}, 32, 6);
    chk("mis_rd_wdata", 32'(cfg_if.wdata), 32'hBEEF);
    chk("mis_rd_strobe", 32'(strobe_cnt), 32'd0);
    chk("mis_rd_oe", 32'(oe_seen), 32'h0);

    clr_mon();
    cap = '0;
    xfer({1'b1, 15'h0010, 16'h0000, 8'h00}, 32, 6);
    chk("rd_data", 32'(cap), 32'hA55A);
    chk("rd_oe_before_fall", 32'(oe_before), 32'h0);
    chk("rd_oe_seen", 32'(oe_seen), 32'h1);
    chk("rd_oe_after_cs", 32'(miso_oe), 32'h0);
    chk("rd_wdata", 32'(cfg_if.wdata), 32'hBEEF);
    chk("rd_strobe", 32'(strobe_cnt), 32'd0);

    clr_mon();
    xfer({1'b0, 15'h0010, 16'h5555, 8'h00}, 24, 6);
    chk("abort_wdata", 32'(cfg_if.wdata), 32'hBEEF);
    chk("abort_strobe", 32'(strobe_cnt), 32'd0);

    clr_mon();
    xfer({1'b0, 15'h0010, 16'h5555, 8'hFF}, 40, 6);
    chk("long_wdata", 32'(cfg_if.wdata), 32'h5555);
    chk("long_strobe", 32'(strobe_cnt), 32'd1);

    clr_mon();
    xfer({1'b0, 15'h0010, 16'h0001, 8'h00}, 32, 4);
    chk("b2b_first_wdata", 32'(cfg_if.wdata), 32'h0001);
    xfer({1'b0, 15'h0010, 16'h0002, 8'h00}, 32, 6);
    chk("b2b_wdata", 32'(cfg_if.wdata), 32'h0002);
    chk("b2b_strobe", 32'(strobe_cnt), 32'd2);

    chk("miso_idle_zero", 32'(miso_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
